// File: rtl/axi4s_pkg.sv
// Shared types and helpers for the AXI4-Stream generator/checker pair.
package axi4s_pkg;

   typedef enum logic {SEED = 1'b0, CHECK = 1'b1} state_e;

   // Fibonacci feedback taps 16,14,13,11 as a mask over state bits [15:0]
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/axi4_stream_data_checker_if.sv
// AXI4-Stream beat signals shared between a source (master) and a sink (slave).
// A beat transfers on a rising clock edge where TVALID and TREADY are both high;
// a master holds TDATA/TKEEP/TLAST stable while TVALID is high and TREADY is low.
interface axi4_stream_data_checker_if #(
   parameter int DATA_WIDTH = 32
);
   logic                    TVALID;
   logic                    TREADY;
   logic [DATA_WIDTH-1:0]   TDATA;
   logic [DATA_WIDTH/8-1:0] TKEEP;
   logic                    TLAST;

   modport master (output TVALID, output TDATA, output TKEEP, output TLAST, input TREADY);
   modport slave  (input TVALID, input TDATA, input TKEEP, input TLAST, output TREADY);
endinterface

// File: rtl/axi4s_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with the feedback bit entering at bit 0.
module axi4s_lfsr16
   import axi4s_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
   input  logic        ACLK,
   input  logic        RSTN,
   input  logic        en_i,
   output logic [15:0] state_o
);
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en_i) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN) lfsr_q <= SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign state_o = lfsr_q;
endmodule

// File: rtl/axi4_stream_data_checker.sv
// Stream sink: checks an incrementing byte-qualified data pattern and packet
// length against TLAST, accumulating packet/error statistics.
module axi4_stream_data_checker
   import axi4s_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          INC        = 1,
   parameter int          BP_EN      = 0,
   parameter logic [15:0] LFSR_SEED  = LFSR_DEFAULT_SEED
) (
   input  logic                       ACLK,
   input  logic                       RSTN,
   input  logic                       enable,
   input  logic                       clear_stats,
   input  logic [31:0]                trans_size,
   axi4_stream_data_checker_if.slave  s_axis,
   output logic [31:0]                pkt_count,
   output logic [31:0]                err_count,
   output logic                       data_err,
   output logic                       len_err,
   output logic                       busy,
   output state_e                     dbg_state_o
);
   localparam int KW = DATA_WIDTH / 8;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic [31:0]           beat_cnt_q, beat_cnt_d;
   logic [31:0]           pkt_count_q, pkt_count_d;
   logic [31:0]           err_count_q, err_count_d;
   logic                  data_err_q, data_err_d;
   logic                  len_err_q, len_err_d;
   logic                  tready_q, tready_d;
   logic [15:0]           lfsr_state;
   logic                  unused_lfsr;
   logic                  accept, null_beat, last_slot, byte_mis, data_bad, len_bad;

   axi4s_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .ACLK    (ACLK),
      .RSTN    (RSTN),
      .en_i    (1'b1),
      .state_o (lfsr_state)
   );
   assign unused_lfsr = ^lfsr_state[15:1];

   assign tready_d  = enable & ((BP_EN != 0) ? lfsr_state[0] : 1'b1);
   assign accept    = s_axis.TVALID & tready_q;
   assign null_beat = (s_axis.TKEEP == '0);
   assign last_slot = (beat_cnt_q == trans_size);

   always_comb begin
      byte_mis = 1'b0;
      for (int b = 0; b < KW; b++) begin
         if (s_axis.TKEEP[b] && (s_axis.TDATA[8*b +: 8] != exp_q[8*b +: 8])) byte_mis = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      beat_cnt_d  = beat_cnt_q;
      pkt_count_d = pkt_count_q;
      err_count_d = err_count_q;
      data_err_d  = data_err_q;
      len_err_d   = len_err_q;
      data_bad    = 1'b0;
      len_bad     = 1'b0;
      if (accept) begin
         // Non-null beats always resynchronise the expectation on what arrived
         if (!null_beat) begin
            data_bad = (state_q == CHECK) && byte_mis;
            state_d  = CHECK;
            exp_d    = s_axis.TDATA + DATA_WIDTH'(INC);
         end
         len_bad    = (s_axis.TLAST != last_slot);
         beat_cnt_d = (s_axis.TLAST || last_slot) ? 32'd0 : beat_cnt_q + 32'd1;
         if (s_axis.TLAST) pkt_count_d = pkt_count_q + 32'd1;
         if (data_bad)     data_err_d  = 1'b1;
         if (len_bad)      len_err_d   = 1'b1;
         if (data_bad || len_bad) err_count_d = sat_inc32(err_count_q);
      end
      if (clear_stats) begin
         pkt_count_d = '0;
         err_count_d = '0;
         data_err_d  = 1'b0;
         len_err_d   = 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= SEED;
         exp_q       <= '0;
         beat_cnt_q  <= '0;
         pkt_count_q <= '0;
         err_count_q <= '0;
         data_err_q  <= 1'b0;
         len_err_q   <= 1'b0;
         tready_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         beat_cnt_q  <= beat_cnt_d;
         pkt_count_q <= pkt_count_d;
         err_count_q <= err_count_d;
         data_err_q  <= data_err_d;
         len_err_q   <= len_err_d;
         tready_q    <= tready_d;
      end
   end

   assign s_axis.TREADY = tready_q;
   assign pkt_count     = pkt_count_q;
   assign err_count     = err_count_q;
   assign data_err      = data_err_q;
   assign len_err       = len_err_q;
   assign busy          = (beat_cnt_q != 32'd0);
   assign dbg_state_o   = state_q;
endmodule
